// File: rtl/svd_pkg.sv
// Shared types and constants for the host-side link to the SVD core.
// Holds the FSM state encoding, result error codes and transfer lengths.
package svd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_TRUNC   = 2'b10;

    localparam int SEND_BEATS = 5;
    localparam int RECV_BYTES = 4;

    // Beat 4 repeats element a: the core reloads a on its fifth input cycle.
    function automatic logic [15:0] send_mux(
        input logic [2:0]  beat,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [15:0] c,
        input logic [15:0] d
    );
        logic [15:0] r;
        case (beat)
            3'd1:    r = b;
            3'd2:    r = c;
            3'd3:    r = d;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/svd_rx_collector.sv
// Result-side receiver: detects the core's ready rising edge, counts and
// captures the four result bytes, and flags a ready drop mid-transfer.
module svd_rx_collector
    import svd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        recv_i,
    input  logic        ready_i,
    input  logic [7:0]  data_i,
    output logic        edge_o,
    output logic        last_o,
    output logic        trunc_o,
    output logic [15:0] s1_o,
    output logic [15:0] s2_o
);

    logic                         ready_q;
    logic [1:0]                   cnt_q, cnt_d;
    logic [RECV_BYTES-1:0][7:0]   bytes_q, bytes_d;

    assign edge_o  = ready_i & ~ready_q;
    assign last_o  = recv_i & ready_i & (cnt_q == 2'(RECV_BYTES - 1));
    assign trunc_o = recv_i & ~ready_i;

    // Bytes arrive low byte first: s1 lo, s1 hi, s2 lo, s2 hi.
    assign s1_o = {bytes_q[1], bytes_q[0]};
    assign s2_o = {bytes_q[3], bytes_q[2]};

    always_comb begin
        cnt_d   = cnt_q;
        bytes_d = bytes_q;
        if (clear_i) begin
            cnt_d   = '0;
            bytes_d = '0;
        end else if (recv_i && ready_i) begin
            bytes_d[cnt_q] = data_i;
            cnt_d          = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            cnt_q   <= '0;
            bytes_q <= '0;
        end else begin
            ready_q <= ready_i;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
        end
    end

endmodule

// File: rtl/svd_host_link.sv
// Host-side link to one SVD core: streams a 2x2 matrix into the core's serial
// port, then collects and returns the two singular values with error status.
module svd_host_link
    import svd_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mat_valid,
    output logic        mat_ready,
    input  logic [15:0] mat_a,
    input  logic [15:0] mat_b,
    input  logic [15:0] mat_c,
    input  logic [15:0] mat_d,
    output logic        svd_data_in,
    output logic [15:0] svd_data_i,
    input  logic [7:0]  svd_data_o_S,
    input  logic        svd_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_s1,
    output logic [15:0] res_s2,
    output logic [1:0]  res_err
);

    state_e             state_q, state_d;
    logic [15:0]        a_q, b_q, c_q, d_q;
    logic [15:0]        a_d, b_d, c_d, d_d;
    logic [2:0]         beat_q, beat_d;
    logic [CNT_W-1:0]   wait_q, wait_d;
    logic [1:0]         err_q, err_d;
    logic               din_q, din_d;
    logic [15:0]        dout_q, dout_d;
    logic               vld_q, vld_d;

    logic               rx_clear;
    logic               rx_edge, rx_last, rx_trunc;

    svd_rx_collector u_rx (
        .clk     (clk),
        .rst     (rst),
        .clear_i (rx_clear),
        .recv_i  (state_q == ST_RECV),
        .ready_i (svd_ready),
        .data_i  (svd_data_o_S),
        .edge_o  (rx_edge),
        .last_o  (rx_last),
        .trunc_o (rx_trunc),
        .s1_o    (res_s1),
        .s2_o    (res_s2)
    );

    assign mat_ready   = (state_q == ST_IDLE) && !rst;
    assign svd_data_in = din_q;
    assign svd_data_i  = dout_q;
    assign res_valid   = vld_q;
    assign res_err     = err_q;

    // Serial-port outputs are computed from the next state so they are
    // registered yet line up with the SEND cycles themselves.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        err_d    = err_q;
        din_d    = 1'b0;
        dout_d   = '0;
        rx_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mat_valid) begin
                    a_d      = mat_a;
                    b_d      = mat_b;
                    c_d      = mat_c;
                    d_d      = mat_d;
                    beat_d   = '0;
                    wait_d   = '0;
                    err_d    = ERR_OK;
                    rx_clear = 1'b1;
                    din_d    = 1'b1;
                    dout_d   = mat_a;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (beat_q == 3'(SEND_BEATS - 1)) begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    beat_d = beat_q + 3'd1;
                    din_d  = 1'b1;
                    dout_d = send_mux(beat_d, a_q, b_q, c_q, d_q);
                end
            end
            ST_WAIT: begin
                wait_d = wait_q + CNT_W'(1);
                if (rx_edge) begin
                    rx_clear = 1'b1;
                    state_d  = ST_RECV;
                end else if (wait_d == CNT_W'(TIMEOUT)) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_DONE;
                end
            end
            ST_RECV: begin
                if (rx_trunc) begin
                    err_d   = ERR_TRUNC;
                    state_d = ST_DONE;
                end else if (rx_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        vld_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            beat_q  <= '0;
            wait_q  <= '0;
            err_q   <= ERR_OK;
            din_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            beat_q  <= beat_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_svd_host_link.sv
// Randomised bench for svd_host_link with a behavioural SVD-core port model
// and a transaction-level reference for results, errors and latencies.
module tb_svd_host_link;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        mat_valid;
    logic        mat_ready;
    logic [15:0] mat_a, mat_b, mat_c, mat_d;
    logic        svd_data_in;
    logic [15:0] svd_data_i;
    logic [7:0]  svd_data_o_S;
    logic        svd_ready;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_s1, res_s2;
    logic [1:0]  res_err;

    int n_cmp = 0;
    int n_bad = 0;

    svd_host_link #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .mat_valid    (mat_valid),
        .mat_ready    (mat_ready),
        .mat_a        (mat_a),
        .mat_b        (mat_b),
        .mat_c        (mat_c),
        .mat_d        (mat_d),
        .svd_data_in  (svd_data_in),
        .svd_data_i   (svd_data_i),
        .svd_data_o_S (svd_data_o_S),
        .svd_ready    (svd_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_s1       (res_s1),
        .res_s2       (res_s2),
        .res_err      (res_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: full result, 1: ready drops after nbytes bytes, 2: core never answers
    task automatic txn(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d,
                       input int mode, input int nbytes, input int dly,
                       input int hold, input logic [31:0] bytes);
        logic [15:0] beats [5];
        logic [7:0]  got_b [4];
        logic [15:0] exp_s1, exp_s2;
        logic [1:0]  exp_err;
        int          t;
        int          n;

        beats = '{a, b, c, d, a};
        t = 0;
        @(negedge clk);
        while (!mat_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", mat_ready, 1);
        mat_valid = 1'b1;
        mat_a = a; mat_b = b; mat_c = c; mat_d = d;

        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            mat_valid = 1'($urandom_range(0, 1));
            mat_a = 16'($urandom); mat_b = 16'($urandom);
            mat_c = 16'($urandom); mat_d = 16'($urandom);
            if (i <= 5) begin
                chk("send_in", svd_data_in, 1);
                chk("send_beat", svd_data_i, beats[i-1]);
            end else begin
                chk("send_end", svd_data_in, 0);
            end
            chk("busy_ready", mat_ready, 0);
        end

        n = (mode == 0) ? 4 : (mode == 1) ? nbytes : 0;
        if (mode == 2) begin
            t = 6;
            while (!res_valid && t < 200) begin
                @(negedge clk);
                t++;
                if (svd_data_in !== 1'b0) chk("wait_in", svd_data_in, 0);
            end
            chk("tmo_latency", t, 5 + TMO + 1);
        end else begin
            repeat (dly) @(negedge clk);
            svd_ready = 1'b1;
            svd_data_o_S = 8'($urandom);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                chk("early_vld", res_valid, 0);
                if (mode == 1 && k == nbytes) begin
                    svd_ready = 1'b0;
                    svd_data_o_S = 8'($urandom);
                    break;
                end
                svd_data_o_S = bytes[8*k +: 8];
            end
            @(negedge clk);
            chk("vld_latency", res_valid, 1);
            svd_data_o_S = 8'($urandom);
        end

        for (int k = 0; k < 4; k++) got_b[k] = (k < n) ? bytes[8*k +: 8] : 8'h00;
        exp_s1  = {got_b[1], got_b[0]};
        exp_s2  = {got_b[3], got_b[2]};
        exp_err = (mode == 2) ? 2'b01 : (n < 4) ? 2'b10 : 2'b00;
        chk("res_s1", res_s1, exp_s1);
        chk("res_s2", res_s2, exp_s2);
        chk("res_err", res_err, exp_err);

        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            svd_ready = 1'b0;
            mat_valid = 1'($urandom_range(0, 1));
            chk("hold_vld", res_valid, 1);
            chk("hold_s1", res_s1, exp_s1);
            chk("hold_s2", res_s2, exp_s2);
            chk("hold_err", res_err, exp_err);
            chk("hold_in", svd_data_in, 0);
            chk("hold_mrdy", mat_ready, 0);
        end
        @(negedge clk);
        svd_ready = 1'b0;
        mat_valid = 1'b0;
        res_ready = 1'b1;
        chk("hs_vld", res_valid, 1);
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_vld", res_valid, 0);
        chk("post_idle", mat_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mat_valid = 1'b0; res_ready = 1'b0; svd_ready = 1'b0;
        mat_a = '0; mat_b = '0; mat_c = '0; mat_d = '0; svd_data_o_S = '0;
        repeat (3) @(negedge clk);
        chk("rst_mrdy", mat_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_mrdy", mat_ready, 1);
        chk("rel_vld", res_valid, 0);
        chk("rel_in", svd_data_in, 0);

        // Reset in the middle of SEND
        mat_valid = 1'b1; mat_a = 16'h1111; mat_b = 16'h2222; mat_c = 16'h3333; mat_d = 16'h4444;
        @(negedge clk);
        mat_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_in", svd_data_in, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in", svd_data_in, 0);
        chk("mid_rst_di", svd_data_i, 0);
        chk("mid_rst_vld", res_valid, 0);
        chk("mid_rst_s", {res_s1, res_s2}, 0);
        chk("mid_rst_err", res_err, 0);
        chk("mid_rst_mrdy", mat_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_rst_mrdy", mat_ready, 1);
        chk("after_rst_in", svd_data_in, 0);

        txn(16'h0100, 16'h0000, 16'h0000, 16'h0080, 0, 4, 3, 10, 32'h5678_1234);
        txn(16'h0100, 16'hFF00, 16'h0040, 16'h0080, 2, 0, 0, 2, 32'h0);
        txn(16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF, 1, 2, 0, 1, 32'h5678_1234);

        for (int r = 0; r < 25; r++) begin
            int m;
            m = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            txn(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                m, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 5)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
